// File: rtl/exibidor_pkg.sv
// Shared definitions for the sequence display: state encodings,
// default LED on/off durations and the timer width helper.
package exibidor_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        AVANCA  = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam int T_ON_PADRAO  = 1000;
    localparam int T_OFF_PADRAO = 500;

    // Width able to hold the larger duration minus one, never below 1 bit.
    function automatic int largura_timer(input int t_on, input int t_off);
        int maior;
        int largura;
        maior   = (t_on > t_off) ? t_on : t_off;
        largura = $clog2(maior);
        if (largura < 1) begin
            largura = 1;
        end else begin
            largura = largura;
        end
        return largura;
    endfunction

endpackage

// File: rtl/exibidor_sequencia_timer.sv
// Saturating cycle timer for the sequence display: clears on zera,
// counts on conta, and flags fim when the count equals limite.
module contador_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zera,
    input  logic             conta,
    input  logic [WIDTH-1:0] limite,
    output logic             fim
);

    logic [WIDTH-1:0] valor_r;

    // Count register: clear has priority, and the count stops at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor_r <= {WIDTH{1'b0}};
        end else if (zera) begin
            valor_r <= {WIDTH{1'b0}};
        end else if (conta && (valor_r != {WIDTH{1'b1}})) begin
            valor_r <= valor_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            valor_r <= valor_r;
        end
    end

    assign fim = (valor_r == limite);

endmodule

// File: rtl/exibidor_sequencia.sv
// Plays back nivel+1 ROM words on the LEDs, each lit for T_ON cycles
// and dark for T_OFF cycles, then pulses pronto.
// Optional feature: define EXIBIDOR_SKIP_EN to add the pular abort input.
module exibidor_sequencia
    import exibidor_pkg::*;
#(
    parameter int T_ON  = T_ON_PADRAO,
    parameter int T_OFF = T_OFF_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] nivel,
    input  logic [3:0] dado_rom,
`ifdef EXIBIDOR_SKIP_EN
    input  logic       pular,
`endif
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] db_estado
);

    localparam int TW = largura_timer(T_ON, T_OFF);
    localparam logic [TW-1:0] LIM_ON  = TW'(T_ON - 1);
    localparam logic [TW-1:0] LIM_OFF = TW'(T_OFF - 1);

    estado_t       estado_r;
    estado_t       proximo_s;
    logic [3:0]    endereco_r;
    logic [3:0]    nivel_r;
    logic          zera_s;
    logic          conta_s;
    logic [TW-1:0] limite_s;
    logic          timer_fim_s;
    logic          limpa_end_s;
    logic          incr_end_s;
    logic          carrega_nivel_s;

    contador_timer #(.WIDTH(TW)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .zera   (zera_s),
        .conta  (conta_s),
        .limite (limite_s),
        .fim    (timer_fim_s)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= proximo_s;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        proximo_s       = estado_r;
        zera_s          = 1'b0;
        conta_s         = 1'b0;
        limite_s        = LIM_ON;
        limpa_end_s     = 1'b0;
        incr_end_s      = 1'b0;
        carrega_nivel_s = 1'b0;
        case (estado_r)
            OCIOSO: begin
                zera_s = 1'b1;
                if (iniciar) begin
                    proximo_s   = CARREGA;
                    limpa_end_s = 1'b1;
                end else begin
                    proximo_s = OCIOSO;
                end
            end
            CARREGA: begin
                zera_s          = 1'b1;
                limpa_end_s     = 1'b1;
                carrega_nivel_s = 1'b1;
                proximo_s       = ACESO;
            end
            ACESO: begin
                limite_s = LIM_ON;
                if (timer_fim_s) begin
                    zera_s    = 1'b1;
                    proximo_s = APAGADO;
                end else begin
                    conta_s = 1'b1;
                end
            end
            APAGADO: begin
                limite_s = LIM_OFF;
                if (timer_fim_s) begin
                    zera_s = 1'b1;
                    // End check comes before any increment, so endereco never wraps.
                    proximo_s = (endereco_r == nivel_r) ? FIM : AVANCA;
                end else begin
                    conta_s = 1'b1;
                end
            end
            AVANCA: begin
                zera_s     = 1'b1;
                incr_end_s = 1'b1;
                proximo_s  = ACESO;
            end
            FIM: begin
                zera_s    = 1'b1;
                proximo_s = OCIOSO;
            end
            default: begin
                zera_s    = 1'b1;
                proximo_s = OCIOSO;
            end
        endcase
`ifdef EXIBIDOR_SKIP_EN
        // Abort: jump straight to FIM, leaving endereco where it is.
        if (pular && ((estado_r == ACESO) || (estado_r == APAGADO) || (estado_r == AVANCA))) begin
            proximo_s  = FIM;
            zera_s     = 1'b1;
            conta_s    = 1'b0;
            incr_end_s = 1'b0;
        end else begin
            proximo_s = proximo_s;
        end
`endif
    end

    // Address counter and latched level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco_r <= 4'd0;
            nivel_r    <= 4'd0;
        end else begin
            if (limpa_end_s) begin
                endereco_r <= 4'd0;
            end else if (incr_end_s) begin
                endereco_r <= endereco_r + 4'd1;
            end else begin
                endereco_r <= endereco_r;
            end
            if (carrega_nivel_s) begin
                nivel_r <= nivel;
            end else begin
                nivel_r <= nivel_r;
            end
        end
    end

    assign endereco  = endereco_r;
    assign leds      = (estado_r == ACESO) ? dado_rom : 4'd0;
    assign ocupado   = (estado_r != OCIOSO);
    assign pronto    = (estado_r == FIM);
    assign db_estado = estado_r;

endmodule

// File: doc/exibidor_sequencia.md
EXIBIDOR_SEQUENCIA -- requirements
Module: exibidor_sequencia

Interface
REQ-001 SHALL provide parameter T_ON, 1000, LED-on cycles per item (>=1).
REQ-002 SHALL provide parameter T_OFF, 500, LED-off cycles per item (>=1).
REQ-003 SHALL provide these ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- iniciar  input  1  start pulse; honoured only in OCIOSO.
- nivel  input  4  last ROM address to display; nivel+1 items are shown.
- dado_rom  input  4  ROM word at endereco (combinational read).
- pular  input  1  abort playback; present only with SKIP_EN.
- endereco  output  4  ROM address of the current item.
- leds  output  4  LED drive.
- ocupado  output  1  high in every state except OCIOSO.
- pronto  output  1  one-cycle end-of-playback pulse.
- db_estado  output  3  state code, for debug.
REQ-004 SHALL use reset reset, asynchronous, active-high; clock clock.

Function
REQ-005 SHALL implement a Moore FSM with states OCIOSO=0, CARREGA=1, ACESO=2, APAGADO=3, AVANCA=4, FIM=5; db_estado SHALL equal the state code.
REQ-006 OCIOSO: iniciar=1 -> CARREGA; otherwise remain in OCIOSO.
REQ-007 CARREGA SHALL clear endereco and the timer, latch nivel into an internal register, and go to ACESO.
REQ-008 ACESO SHALL drive leds=dado_rom and count the timer; at timer==T_ON-1, clear the timer and go to APAGADO.
REQ-009 APAGADO SHALL drive leds=0 and count the timer; at timer==T_OFF-1, go to FIM if endereco==latched nivel, else to AVANCA.
REQ-010 AVANCA SHALL increment endereco by 1, clear the timer, and go to ACESO.
REQ-011 FIM SHALL assert pronto for exactly one cycle and then go to OCIOSO; endereco SHALL hold its value.
REQ-012 leds SHALL be 0 in every state except ACESO.
REQ-013 Latency: with iniciar sampled at cycle 0, CARREGA is at cycle 1, the first lit cycle is cycle 2, and FIM is at cycle 1+(n+1)(T_ON+T_OFF)+n+1, where n is the latched nivel.
REQ-014 iniciar while ocupado=1 SHALL be ignored.
REQ-015 Changes to nivel after CARREGA SHALL have no effect on the current playback.
REQ-016 endereco SHALL never wrap: with nivel=15 it stops at 15, because the FIM check precedes any increment.
REQ-017 Timer width SHALL be $clog2 of the larger of T_ON and T_OFF, with a minimum of 1 bit; the timer saturates and never overflows.

Reset
REQ-018 reset SHALL immediately force OCIOSO, endereco=0, timer=0, latched nivel=0, leds=0, pronto=0, ocupado=0, db_estado=0.
REQ-019 Reset asserted mid-playback SHALL abort the playback without a pronto pulse.
REQ-020 The first iniciar after reset is released SHALL start a normal playback.

Configuration
REQ-021 With macro EXIBIDOR_SKIP_EN defined, port pular SHALL exist; pular=1 in ACESO, APAGADO or AVANCA SHALL force FIM on the next edge, and pronto SHALL then pulse normally.
REQ-022 Without EXIBIDOR_SKIP_EN, port pular and all associated logic SHALL be absent, and behaviour SHALL be exactly REQ-005..REQ-017.

Structure
REQ-023 A shared package (exibidor_pkg) SHALL hold the state encodings and the default T_ON/T_OFF constants.
REQ-024 The timer SHALL be a sub-module contador_timer with ports zera, conta, limite and fim; the FSM and address counter stay in exibidor_sequencia.

Verification (bench parameters T_ON=4, T_OFF=2)
REQ-025 Reset: assert reset mid-clock -> all outputs 0 and db_estado=0 without waiting for a clock edge.
REQ-026 Single item: nivel=0, ROM[0]=0001, iniciar at cycle 0 -> leds=0001 for cycles 2-5, leds=0 for cycles 6-7, pronto only at cycle 8, ocupado high for cycles 1-8.
REQ-027 Three items: nivel=2, ROM={0001,0010,0100}:
- endereco=0/1/2 lit at cycles 2-5, 9-12 and 16-19.
- AVANCA at cycles 8 and 15.
- pronto at cycle 22.
REQ-028 Ignore rules: run the REQ-027 stimulus, set nivel=5 at cycle 3 and re-pulse iniciar at cycle 10 -> waveform identical to REQ-027, pronto at cycle 22.
REQ-029 Reset mid-run: run the REQ-027 stimulus, pulse reset at cycle 11 -> leds=0, no pronto pulse; a new iniciar gives REQ-027 timing relative to the new start.
REQ-030 Skip (EXIBIDOR_SKIP_EN defined): run the REQ-027 stimulus, pular=1 at cycle 10 -> FIM and pronto at cycle 11, OCIOSO at cycle 12; build without the macro -> pular port absent.
